// File: rtl/exe_div.sv
// exe_div: iterative restoring divider for RISC-V DIV/DIVU/REM/REMU in the EXE stage
module exe_div #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [31:0]       inst_i,
    input  logic [DATA_W-1:0] op1_i,
    input  logic [DATA_W-1:0] op2_i,
    input  logic [4:0]        reg_waddr_i,
    input  logic              flush_i,
    output logic              stall_req_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              reg_we_o,
    output logic [4:0]        reg_waddr_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [DATA_W-1:0]   spec_val_q, spec_val_d, result_q, result_d;
    logic                sq_q, sq_d, sr_q, sr_d, want_rem_q, want_rem_d, spec_q, spec_d;
    logic [4:0]          waddr_q, waddr_d;

    logic [2:0]          funct3;
    logic                is_div, is_signed, start, div_zero, overflow;
    logic [DATA_W-1:0]   min_neg, abs1, abs2, res_calc, res_fin;
    logic [DATA_W:0]     rem_sh;
    logic [DATA_W+1:0]   trial;
    logic                unused_inst;

    assign funct3      = inst_i[14:12];
    assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};
    assign is_div      = (inst_i[6:0] == 7'b0110011) && (inst_i[31:25] == 7'b0000001) && funct3[2];
    assign is_signed   = ~funct3[0];
    assign start       = (state_q == IDLE) && is_div && !flush_i;
    assign min_neg     = {1'b1, {(DATA_W-1){1'b0}}};
    assign div_zero    = (op2_i == '0);
    assign overflow    = is_signed && (op1_i == min_neg) && (&op2_i);
    assign abs1        = (is_signed && op1_i[DATA_W-1]) ? -op1_i : op1_i;
    assign abs2        = (is_signed && op2_i[DATA_W-1]) ? -op2_i : op2_i;

    // The partial remainder can reach 2*divisor-1, so the shifted value and the trial keep extra bits
    assign rem_sh      = {rem_q, quo_q[DATA_W-1]};
    assign trial       = {1'b0, rem_sh} - {2'b00, dvs_q};
    assign res_calc    = want_rem_q ? (sr_q ? -rem_q : rem_q) : (sq_q ? -quo_q : quo_q);
    assign res_fin     = spec_q ? spec_val_q : res_calc;

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE) && !flush_i;
    assign reg_we_o    = done_o;
    assign stall_req_o = rst_n_i && (start || ((state_q == CALC) && !flush_i));
    assign result_o    = done_o ? res_fin : result_q;
    assign reg_waddr_o = waddr_q;

    // Next-state logic: capture operands at start, one quotient bit per CALC cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        sq_d       = sq_q;
        sr_d       = sr_q;
        want_rem_d = want_rem_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        waddr_d    = waddr_q;
        result_d   = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d      = '0;
                    quo_d      = abs1;
                    dvs_d      = abs2;
                    sq_d       = is_signed & (op1_i[DATA_W-1] ^ op2_i[DATA_W-1]);
                    sr_d       = is_signed & op1_i[DATA_W-1];
                    want_rem_d = funct3[1];
                    waddr_d    = reg_waddr_i;
                    spec_d     = div_zero | overflow;
                    spec_val_d = div_zero ? (funct3[1] ? op1_i : '1) : (funct3[1] ? '0 : min_neg);
                    cnt_d      = CNT_W'(DATA_W);
                    state_d    = (div_zero | overflow) ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d   = trial[DATA_W+1] ? rem_sh[DATA_W-1:0] : trial[DATA_W-1:0];
                    quo_d   = {quo_q[DATA_W-2:0], ~trial[DATA_W+1]};
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == CNT_W'(1)) ? DONE : CALC;
                end
            end
            DONE: begin
                state_d  = IDLE;
                result_d = flush_i ? result_q : res_fin;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            sq_q       <= 1'b0;
            sr_q       <= 1'b0;
            want_rem_q <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            waddr_q    <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            sq_q       <= sq_d;
            sr_q       <= sr_d;
            want_rem_q <= want_rem_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            waddr_q    <= waddr_d;
            result_q   <= result_d;
        end
    end
endmodule

// File: tb/tb_exe_div.sv
// tb_exe_div: directed scoreboard bench for the EXE-stage divider
module tb_exe_div;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] inst_i, op1_i, op2_i;
    logic [4:0]  reg_waddr_i;
    logic        flush_i;
    logic        stall_req_o, busy_o, done_o, reg_we_o;
    logic [31:0] result_o;
    logic [4:0]  reg_waddr_o;

    int tot = 0;
    int bad = 0;
    logic [31:0] exp_res_q[$];
    logic [4:0]  exp_wa_q[$];
    int          exp_cyc_q[$];

    exe_div #(.DATA_W(32), .CNT_W(6)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .inst_i(inst_i), .op1_i(op1_i), .op2_i(op2_i),
        .reg_waddr_i(reg_waddr_i), .flush_i(flush_i), .stall_req_o(stall_req_o),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .reg_we_o(reg_we_o),
        .reg_waddr_o(reg_waddr_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic bit is_spec(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_f(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
        if (!f3[0]) return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
        return f3[1] ? a % b : a / b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic run_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input string tag);
        int cyc, c;
        bit got, stall_ok;
        logic [31:0] r;
        logic [4:0] w;
        exp_res_q.push_back(ref_f(f3, a, b));
        exp_wa_q.push_back(rd);
        exp_cyc_q.push_back(is_spec(f3, a, b) ? 2 : 34);
        inst_i = mk(7'b0000001, f3, rd);
        op1_i = a;
        op2_i = b;
        reg_waddr_i = rd;
        cyc = 1;
        got = 0;
        stall_ok = 1;
        while (!got && cyc <= 40) begin
            #1;
            if (done_o) begin
                got = 1;
            end else begin
                if (stall_req_o !== 1'b1) stall_ok = 0;
                @(posedge clk_i);
                #1;
                cyc++;
                op1_i = $urandom;
                op2_i = $urandom;
                reg_waddr_i = 5'($urandom);
            end
        end
        r = exp_res_q.pop_front();
        w = exp_wa_q.pop_front();
        c = exp_cyc_q.pop_front();
        chk({tag, "_done"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_res"}, result_o, r);
            chk({tag, "_waddr"}, 32'(reg_waddr_o), 32'(w));
            chk({tag, "_lat"}, 32'(cyc), 32'(c));
            chk({tag, "_stall"}, 32'(stall_ok), 32'd1);
            chk({tag, "_we"}, 32'(reg_we_o), 32'd1);
            chk({tag, "_stall_done"}, 32'(stall_req_o), 32'd0);
        end
        @(posedge clk_i);
        #1;
        inst_i = 32'h0000_0013;
        #1;
        chk({tag, "_pulse"}, 32'(done_o), 32'd0);
        chk({tag, "_hold"}, result_o, r);
        chk({tag, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int dn, st;
        rst_n_i = 1'b0;
        inst_i = 32'd0;
        op1_i = 32'd0;
        op2_i = 32'd0;
        reg_waddr_i = 5'd0;
        flush_i = 1'b0;
        #12;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_stall", 32'(stall_req_o), 32'd0);
        chk("rst_res", result_o, 32'd0);
        chk("rst_waddr", 32'(reg_waddr_o), 32'd0);
        chk("rst_we", 32'(reg_we_o), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        inst_i = mk(7'b0000000, 3'b000, 5'd3);
        #1;
        chk("add_stall", 32'(stall_req_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("add_busy", 32'(busy_o), 32'd0);
        inst_i = mk(7'b0000001, 3'b000, 5'd3);
        #1;
        chk("mul_stall", 32'(stall_req_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("mul_busy", 32'(busy_o), 32'd0);
        inst_i = mk(7'b0000001, 3'b100, 5'd3);
        op2_i = 32'd3;
        flush_i = 1'b1;
        #1;
        chk("flush_idle_stall", 32'(stall_req_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("flush_idle_busy", 32'(busy_o), 32'd0);
        flush_i = 1'b0;
        inst_i = 32'h0000_0013;
        @(posedge clk_i);
        #1;
        run_div(3'b101, 32'd100, 32'd7, 5'd5, "divu_100_7");
        run_div(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, "rem_m7_2");
        run_div(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, "div_m7_2");
        run_div(3'b100, 32'd5, 32'd0, 5'd8, "div_by0");
        run_div(3'b111, 32'd5, 32'd0, 5'd9, "remu_by0");
        run_div(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, "div_ovf");
        run_div(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, "rem_ovf");
        run_div(3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 5'd12, "divu_big");
        run_div(3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 5'd13, "remu_big");
        run_div(3'b100, 32'd100, 32'hFFFF_FFF9, 5'd14, "div_100_m7");
        run_div(3'b110, 32'd100, 32'hFFFF_FFF9, 5'd15, "rem_100_m7");
        run_div(3'b110, 32'hFFFF_FF9C, 32'd7, 5'd16, "rem_m100_7");
        run_div(3'b101, 32'hDEAD_BEEF, 32'd1, 5'd17, "divu_by1");
        run_div(3'b100, 32'h8000_0000, 32'd1, 5'd18, "div_min_1");
        inst_i = mk(7'b0000001, 3'b101, 5'd9);
        op1_i = 32'd1000;
        op2_i = 32'd3;
        reg_waddr_i = 5'd9;
        repeat (10) @(posedge clk_i);
        #1;
        chk("fl_calc_busy", 32'(busy_o), 32'd1);
        flush_i = 1'b1;
        #1;
        chk("fl_stall_now", 32'(stall_req_o), 32'd0);
        chk("fl_done_now", 32'(done_o), 32'd0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        inst_i = mk(7'b0000000, 3'b000, 5'd3);
        #1;
        chk("fl_after_busy", 32'(busy_o), 32'd0);
        chk("fl_after_stall", 32'(stall_req_o), 32'd0);
        dn = 0;
        st = 0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            dn += int'(done_o);
            st += int'(stall_req_o);
        end
        chk("fl_no_done", 32'(dn), 32'd0);
        chk("fl_no_stall", 32'(st), 32'd0);
        inst_i = mk(7'b0000001, 3'b101, 5'd4);
        op1_i = 32'd77;
        op2_i = 32'd5;
        reg_waddr_i = 5'd4;
        repeat (5) @(posedge clk_i);
        #1;
        chk("rs_calc_busy", 32'(busy_o), 32'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("rs_busy", 32'(busy_o), 32'd0);
        chk("rs_stall", 32'(stall_req_o), 32'd0);
        chk("rs_done", 32'(done_o), 32'd0);
        chk("rs_res", result_o, 32'd0);
        chk("rs_waddr", 32'(reg_waddr_o), 32'd0);
        inst_i = 32'h0000_0013;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        run_div(3'b101, 32'd9, 32'd3, 5'd20, "divu_9_3");
        chk("sb_empty", 32'(exp_res_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule

// File: doc/exe_div.md
Name: exe_div

Overview:
- Iterative 32-bit RISC-V M-extension divider inside the EXE stage.
- Takes the instruction and operands registered by the ID/EXE pipeline register.
- Holds the pipeline through stall_req_o while it computes, then presents the quotient or remainder for the EXE result mux.
- Covers DIV, DIVU, REM and REMU. All other instructions pass through with no effect.

Parameters:
- DATA_W, 32, operand and result width.
- CNT_W, 6, width of the iteration counter. Must satisfy 2^CNT_W > DATA_W.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- inst_i  in  32  instruction from the ID/EXE register.
- op1_i  in  DATA_W  dividend (rs1).
- op2_i  in  DATA_W  divisor (rs2).
- reg_waddr_i  in  5  destination register.
- flush_i  in  1  jump flush; abort the current operation.
- stall_req_o  out  1  request to stall the IF through EXE stages (drives the stall_i[3] source).
- busy_o  out  1  FSM not in IDLE.
- done_o  out  1  result valid, one-cycle pulse.
- result_o  out  DATA_W  quotient or remainder.
- reg_we_o  out  1  write enable for the result; equals done_o.
- reg_waddr_o  out  5  destination register latched at start.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n_i is asynchronous, active-low.
- Reset values: state=IDLE, counter=0, all outputs 0.
- Decode: is_div = (opcode==7'b0110011) && (funct7==7'b0000001) && funct3[2].
  - funct3 100 = DIV, 101 = DIVU, 110 = REM, 111 = REMU.
  - signed = ~funct3[0].
  - want_rem = funct3[1].
- stall_req_o = (state==IDLE && is_div && !flush_i) || state==CALC. It is low in DONE, so the ID/EXE register loads the next instruction at the DONE edge.
- IDLE:
  - If is_div && !flush_i, latch the following, then go to DONE if a special case applies, else to CALC with counter=DATA_W:
    - |op1| and |op2| (magnitudes when signed, raw values when unsigned);
    - the sign of the quotient, sq = signed & (op1[31]^op2[31]);
    - the sign of the remainder, sr = signed & op1[31];
    - want_rem and reg_waddr_i.
  - Otherwise stay in IDLE.
- Special cases, resolved in IDLE and sent straight to DONE:
  - Divisor == 0: quotient = all ones; remainder = op1_i.
  - Signed, op1 == 32'h8000_0000 and op2 == 32'hFFFF_FFFF: quotient = 32'h8000_0000; remainder = 0.
- CALC (restoring division, one bit per cycle):
  - {rem,quo} shifts left by 1.
  - Trial = rem_shifted - divisor, computed DATA_W+1 bits wide.
  - If the trial is non-negative: rem = trial and quo[0] = 1.
  - Counter decrements; on counter==1 the next state is DONE.
  - CALC lasts exactly DATA_W cycles.
- DONE (one cycle):
  - done_o = reg_we_o = 1.
  - result_o = want_rem ? (sr ? -rem : rem) : (sq ? -quo : quo).
  - The special-case value overrides this if one was flagged.
  - Next state is IDLE unconditionally.
- Latency:
  - Normal: the instruction occupies EXE for DATA_W+2 cycles (1 IDLE + 32 CALC + 1 DONE); result in cycle 34 counted from EXE entry.
  - Special case: 2 cycles.
- Outside DONE: result_o and reg_waddr_o hold their last values. done_o and reg_we_o are 0.
- flush_i:
  - In CALC or DONE: next state is IDLE, no done pulse, stall_req_o drops in the same cycle.
  - In IDLE: suppresses the start.
- Back-to-back divides: the second divide enters EXE the cycle after DONE and starts normally from IDLE.
- Reset asserted mid-operation: immediate return to IDLE and outputs cleared. After deassertion the first edge samples normally.
- Operands are captured at start. Changes on op1_i or op2_i during CALC are ignored.

Test Plan:
- DIVU 100/7 (op1=100, op2=7, funct3=101) -> stall_req_o high for 33 cycles; done_o pulses in cycle 34; result_o=14; reg_waddr_o=latched rd.
- REM -7 % 2 (op1=32'hFFFF_FFF9, op2=2, funct3=110) -> result_o=32'hFFFF_FFFF (-1). DIV with the same operands -> 32'hFFFF_FFFD (-3).
- DIV by zero (op1=5, op2=0) -> done at cycle 2, result 32'hFFFF_FFFF. REMU with op1=5, op2=0 -> result 5.
- Signed overflow: DIV 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000 at cycle 2. REM with the same operands -> 0.
- flush_i pulsed at CALC cycle 10 -> next cycle state IDLE, stall_req_o=0, no done_o. A following ADD causes no stall.
- rst_n_i asserted low asynchronously at CALC cycle 5 -> busy_o, stall_req_o and done_o go 0 immediately. A DIVU 9/3 issued after release -> result 3 at cycle 34.
